// File: rtl/fp32_adder_arbiter.sv
// rtl/fp32_adder_arbiter.sv - round-robin sharing of one pipelined fp32 adder; FP32_ADDER_ARB_CNT_EN adds grant_cnt_o
module fp32_adder_arbiter #(
  parameter int REQ_NUM   = 4,
  parameter int ADDER_LAT = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [REQ_NUM-1:0]    req_valid_i,
  output logic [REQ_NUM-1:0]    req_ready_o,
  input  logic [REQ_NUM*32-1:0] req_a_i,
  input  logic [REQ_NUM*32-1:0] req_b_i,
  output logic [REQ_NUM-1:0]    res_valid_o,
  output logic [31:0]           res_z_o,
  output logic                  adder_valid_stb_o,
  output logic [31:0]           adder_a_o,
  output logic [31:0]           adder_b_o,
  input  logic [31:0]           adder_z_i
`ifdef FP32_ADDER_ARB_CNT_EN
  ,
  output logic [REQ_NUM*16-1:0] grant_cnt_o
`endif
);

  localparam int ID_W = $clog2(REQ_NUM);

  logic [ID_W-1:0]                 ptr_q, ptr_d;
  logic [2*REQ_NUM-1:0]            valid_dbl;
  logic [REQ_NUM-1:0]              valid_rot;
  logic                            found;
  logic [ID_W:0]                   offset;
  logic [ID_W:0]                   id_sum;
  logic [ID_W-1:0]                 grant_id;
  logic                            transfer;
  logic [REQ_NUM-1:0]              grant;

  logic                            issue_vld_q, issue_vld_d;
  logic [ID_W-1:0]                 issue_id_q, issue_id_d;
  logic [31:0]                     adder_a_q, adder_a_d;
  logic [31:0]                     adder_b_q, adder_b_d;

  logic [ADDER_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [ADDER_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

  logic [REQ_NUM-1:0]              res_vld_q, res_vld_d;
  logic [31:0]                     res_z_q, res_z_d;

  // Round-robin scan: rotate requests so the pointer lands on bit 0, then pick the lowest set bit.
  always_comb begin
    valid_dbl = {req_valid_i, req_valid_i};
    valid_rot = REQ_NUM'(valid_dbl >> ptr_q);
    found     = 1'b0;
    offset    = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        found  = 1'b1;
        offset = (ID_W+1)'(k);
      end
    end
    id_sum = {1'b0, ptr_q} + offset;
    if (id_sum >= (ID_W+1)'(REQ_NUM)) begin
      id_sum = id_sum - (ID_W+1)'(REQ_NUM);
    end
    grant_id = id_sum[ID_W-1:0];
    transfer = found & ~srst;
    grant    = transfer ? (REQ_NUM'(1) << grant_id) : '0;
  end

  assign req_ready_o = grant;

  // Next state for pointer, issue stage, tag shift register and result stage.
  always_comb begin
    ptr_d       = ptr_q;
    issue_vld_d = transfer;
    issue_id_d  = issue_id_q;
    adder_a_d   = adder_a_q;
    adder_b_d   = adder_b_q;
    if (transfer) begin
      ptr_d      = (grant_id == ID_W'(REQ_NUM - 1)) ? '0 : grant_id + 1'b1;
      issue_id_d = grant_id;
      adder_a_d  = req_a_i[32*grant_id +: 32];
      adder_b_d  = req_b_i[32*grant_id +: 32];
    end

    // Stage 0 loads when the adder samples the issue registers, so the last stage lines up with adder_z_i.
    tag_vld_d[0] = issue_vld_q;
    tag_id_d[0]  = issue_id_q;
    for (int s = 1; s < ADDER_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    res_vld_d = '0;
    res_z_d   = res_z_q;
    if (tag_vld_q[ADDER_LAT-1]) begin
      res_vld_d = REQ_NUM'(1) << tag_id_q[ADDER_LAT-1];
      res_z_d   = adder_z_i;
    end
  end

  // State registers; reset drops every in-flight tag so late adder results are ignored.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_q       <= '0;
      issue_vld_q <= 1'b0;
      issue_id_q  <= '0;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      res_vld_q   <= '0;
      res_z_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      issue_vld_q <= issue_vld_d;
      issue_id_q  <= issue_id_d;
      adder_a_q   <= adder_a_d;
      adder_b_q   <= adder_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      res_vld_q   <= res_vld_d;
      res_z_q     <= res_z_d;
    end
  end

  assign adder_valid_stb_o = issue_vld_q;
  assign adder_a_o         = adder_a_q;
  assign adder_b_o         = adder_b_q;
  assign res_valid_o       = res_vld_q;
  assign res_z_o           = res_z_q;

`ifdef FP32_ADDER_ARB_CNT_EN
  logic [REQ_NUM-1:0][15:0] cnt_q, cnt_d;

  // Per-requester grant counters that stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fp32_adder_arbiter.sv
// tb/tb_fp32_adder_arbiter.sv - randomized self-checking bench for fp32_adder_arbiter (FP32_ADDER_ARB_CNT_EN optional)
module tb_fp32_adder_arbiter;

  localparam int N   = 4;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            srst;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*32-1:0] req_a_i;
  logic [N*32-1:0] req_b_i;
  logic [N-1:0]    res_valid_o;
  logic [31:0]     res_z_o;
  logic            adder_valid_stb_o;
  logic [31:0]     adder_a_o;
  logic [31:0]     adder_b_o;
  logic [31:0]     adder_z_i;
`ifdef FP32_ADDER_ARB_CNT_EN
  logic [N*16-1:0] grant_cnt_o;
`endif

  fp32_adder_arbiter #(.REQ_NUM(N), .ADDER_LAT(LAT)) dut (
    .clk               (clk),
    .srst              (srst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_a_i           (req_a_i),
    .req_b_i           (req_b_i),
    .res_valid_o       (res_valid_o),
    .res_z_o           (res_z_o),
    .adder_valid_stb_o (adder_valid_stb_o),
    .adder_a_o         (adder_a_o),
    .adder_b_o         (adder_b_o),
    .adder_z_i         (adder_z_i)
`ifdef FP32_ADDER_ARB_CNT_EN
    ,
    .grant_cnt_o       (grant_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Operands are multiples of 0.5 (value k/2), so the stand-in adder is exact integer arithmetic.
  function automatic logic [31:0] enc(input int unsigned k);
    int e;
    logic [31:0] r;
    if (k == 0) return 32'h0;
    e = 0;
    for (int i = 0; i < 24; i++) if (k[i]) e = i;
    r = {1'b0, 8'(126 + e), 23'(k << (23 - e))};
    return r;
  endfunction

  function automatic int unsigned dec(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 126;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return enc(dec(a) + dec(b));
  endfunction

  // Stand-in adder: LAT registered stages, result readable LAT edges after the sampling edge.
  logic [31:0] apipe [LAT];
  always_ff @(posedge clk) begin
    apipe[0] <= fadd(adder_a_o, adder_b_o);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign adder_z_i = apipe[LAT-1];

  logic [31:0]  op_a [N];
  logic [31:0]  op_b [N];
  logic [N-1:0] vld;

  always_comb begin
    req_valid_i = vld;
    for (int i = 0; i < N; i++) begin
      req_a_i[32*i +: 32] = op_a[i];
      req_b_i[32*i +: 32] = op_b[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] z;
  } pend_t;

  // Reference model state
  pend_t       pend[$];
  int          ptr = 0;
  int          cyc = 0;
  logic        m_stb = 1'b0;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;
  logic [31:0] m_resz = 32'h0;
  int          m_cnt [N];
  int          last_g = -1;

  // Observations of the DUT used by scenario checks
  int          glog[$];
  int          rlog[$];
  int          seen_rv [N];

  // One clock: check mid-cycle, then advance the model on the edge.
  task automatic step();
    int          g;
    int          dg;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    @(negedge clk);
    g = -1;
    if (!srst) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (g < 0 && vld[i]) g = i;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    check_eq("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    check_eq("adder_stb", 64'(adder_valid_stb_o), 64'(m_stb));
    check_eq("adder_a", 64'(adder_a_o), 64'(m_a));
    check_eq("adder_b", 64'(adder_b_o), 64'(m_b));
    exp_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv = N'(1 << pend[0].id);
      m_resz = pend[0].z;
      void'(pend.pop_front());
    end
    check_eq("res_valid", 64'(res_valid_o), 64'(exp_rv));
    check_eq("res_z", 64'(res_z_o), 64'(m_resz));
`ifdef FP32_ADDER_ARB_CNT_EN
    for (int i = 0; i < N; i++) check_eq("grant_cnt", 64'(grant_cnt_o[16*i +: 16]), 64'(m_cnt[i]));
`endif
    dg = -1;
    for (int i = 0; i < N; i++) begin
      if (req_ready_o[i]) dg = i;
      if (res_valid_o[i]) begin
        seen_rv[i]++;
        rlog.push_back(i);
      end
    end
    if (dg >= 0) glog.push_back(dg);

    @(posedge clk);
    cyc++;
    if (srst) begin
      ptr    = 0;
      m_stb  = 1'b0;
      m_a    = 32'h0;
      m_b    = 32'h0;
      m_resz = 32'h0;
      pend.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      last_g = -1;
    end else begin
      m_stb  = (g >= 0);
      last_g = g;
      if (g >= 0) begin
        m_a = op_a[g];
        m_b = op_b[g];
        ptr = (g + 1) % N;
        pend.push_back('{due: cyc + LAT + 1, id: g, z: fadd(op_a[g], op_b[g])});
        if (m_cnt[g] < 65535) m_cnt[g]++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    vld = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic all_four();
    int base;
    base = glog.size();
    vld = '1;
    for (int i = 0; i < N; i++) begin
      op_a[i] = enc($urandom_range(1, 4000));
      op_b[i] = enc($urandom_range(1, 4000));
    end
    for (int c = 0; c < N; c++) begin
      step();
      if (last_g >= 0) vld[last_g] = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (glog.size() > base + k) check_eq("all4_grant_order", 64'(glog[base+k]), 64'(k));
      else check_eq("all4_grant_missing", 64'(glog.size()), 64'(base + k + 1));
    end
  endtask

  initial begin
    int base;
    int rv_before;
    srst = 1'b1;
    vld  = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i]    = 32'h0;
      op_b[i]    = 32'h0;
      m_cnt[i]   = 0;
      seen_rv[i] = 0;
    end
    @(posedge clk);
    #1;
    step();
    srst = 1'b0;

    // Single request: 1.0 + 2.0 from requester 0
    op_a[0] = 32'h3F800000;
    op_b[0] = 32'h40000000;
    vld     = 4'b0001;
    step();
    idle(8);
    check_eq("single_rv_count", 64'(seen_rv[0]), 64'd1);
    check_eq("single_z", 64'(res_z_o), 64'h40400000);

    // All four valid straight after reset; results come back in grant order
    srst = 1'b1;
    step();
    srst = 1'b0;
    base = rlog.size();
    all_four();
    idle(8);
    for (int k = 0; k < N; k++) begin
      if (rlog.size() > base + k) check_eq("all4_result_order", 64'(rlog[base+k]), 64'(k));
      else check_eq("all4_result_missing", 64'(rlog.size()), 64'(base + k + 1));
    end

    // Fairness: requesters 0 and 2 held valid, grants alternate
    base = glog.size();
    vld  = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      step();
      if (last_g >= 0) begin
        op_a[last_g] = enc($urandom_range(1, 4000));
        op_b[last_g] = enc($urandom_range(1, 4000));
      end
    end
    for (int k = base; k < base + 10; k++) begin
      if (glog.size() > k) check_eq("fair_alternate", 64'(glog[k]), 64'(((k - base) % 2) * 2));
      else check_eq("fair_missing", 64'(glog.size()), 64'(k + 1));
    end
    idle(8);

    // Back-to-back: requester 1 alone, 1.5 + 2.5 five times
    rv_before = seen_rv[1];
    op_a[1]   = 32'h3FC00000;
    op_b[1]   = 32'h40200000;
    vld       = 4'b0010;
    for (int c = 0; c < 5; c++) step();
    idle(8);
    check_eq("b2b_rv_count", 64'(seen_rv[1] - rv_before), 64'd5);
    check_eq("b2b_z", 64'(res_z_o), 64'h40800000);

    // Reset mid-flight: three ops issued, reset two cycles later, nothing returns
    rv_before = rlog.size();
    op_a[1]   = enc(7);
    op_b[1]   = enc(9);
    vld       = 4'b0010;
    for (int c = 0; c < 3; c++) step();
    idle(2);
    srst = 1'b1;
    step();
    srst = 1'b0;
    idle(10);
    check_eq("reset_drops_results", 64'(rlog.size()), 64'(rv_before));
    base = glog.size();
    vld  = '1;
    step();
    if (glog.size() > base) check_eq("reset_ptr_first_grant", 64'(glog[base]), 64'd0);
    else check_eq("reset_ptr_no_grant", 64'(glog.size()), 64'(base + 1));
    idle(8);

    // Counters: three rounds of all-four from reset
    srst = 1'b1;
    step();
    srst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      all_four();
      idle(2);
    end
    idle(6);
`ifdef FP32_ADDER_ARB_CNT_EN
    for (int i = 0; i < N; i++) check_eq("cnt_three", 64'(grant_cnt_o[16*i +: 16]), 64'd3);
    srst = 1'b1;
    step();
    srst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_eq("cnt_cleared", 64'(grant_cnt_o[16*i +: 16]), 64'd0);
`endif

    // Randomized traffic with held operands and occasional resets
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(vld[i] && last_g != i)) begin
          vld[i]  = 1'($urandom_range(0, 1));
          op_a[i] = enc($urandom_range(1, 4000));
          op_b[i] = enc($urandom_range(1, 4000));
        end
      end
      srst = ($urandom_range(0, 63) == 0);
      step();
    end
    srst = 1'b0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
